cp0_unit: RTL and testbench



---
 rtl/cp0_unit.sv | 102 ++++++++++
 tb/tb_cp0_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller: SR/Cause/EPC/PRId registers,
// combinational take-request, and mtc0/mfc0/eret handling.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2022_0202
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_rd_data;

  // Interrupts take priority; EXL masks both sources until cleared.
  assign w_int_req = ~r_exl & r_ie & (|(hw_int & r_im));
  assign w_exc_req = ~r_exl & (exc_code_in != 5'd0);
  assign w_req     = ~reset & (w_int_req | w_exc_req);
  assign req       = w_req;

  assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
  assign w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_exc_code, 2'b00};

  // Register state: exception capture, mtc0 writes, eret, interrupt pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= 6'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'h0000_0000;
    end else begin
      r_ip <= hw_int;
      if (w_req) begin
        r_exl      <= 1'b1;
        r_bd       <= bd_in;
        r_exc_code <= w_int_req ? 5'd0 : exc_code_in;
        r_epc      <= bd_in ? (vpc - 32'd4) : vpc;
      end else begin
        if (en) begin
          case (cp0_addr)
            ADDR_SR: begin
              r_im  <= cp0_in[15:10];
              r_exl <= cp0_in[1];
              r_ie  <= cp0_in[0];
            end
            ADDR_EPC: r_epc <= cp0_in;
            default: ;
          endcase
        end
        // eret overrides an SR write for EXL only
        if (exl_clr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux; no bypass of same-cycle writes.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    case (cp0_addr)
      ADDR_SR:    w_rd_data = w_sr;
      ADDR_CAUSE: w_rd_data = w_cause;
      ADDR_EPC:   w_rd_data = r_epc;
      ADDR_PRID:  w_rd_data = PRID;
      default:    w_rd_data = 32'h0000_0000;
    endcase
  end

  assign cp0_out = w_rd_data;
  assign epc_out = r_epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized traffic
// compared against a register-level behavioural model.
module tb_cp0_unit;
  localparam logic [31:0] PRID = 32'h2022_0202;

  logic        clk = 1'b0;
  logic        reset, en, bd_in, exl_clr, req;
  logic [4:0]  cp0_addr, exc_code_in;
  logic [31:0] cp0_in, vpc, cp0_out, epc_out;
  logic [5:0]  hw_int;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_sr = 32'h0, m_cause = 32'h0, m_epc = 32'h0;
  logic        m_valid = 1'b0;
  logic [4:0]  codes [8] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

  always #10 clk = ~clk;

  cp0_unit #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
    .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
    .hw_int(hw_int), .exl_clr(exl_clr), .epc_out(epc_out), .req(req)
  );

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return !m_sr[1] && m_sr[0] && ((hw_int & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_req();
    if (reset) return 1'b0;
    return m_int() || (!m_sr[1] && exc_code_in != 5'd0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, then advance the model at the edge.
  task automatic tick(input string tag);
    logic r, i;
    #2;
    check({tag, "_req"}, {31'd0, req}, {31'd0, m_req()});
    if (m_valid) begin
      check({tag, "_rd"}, cp0_out, m_read(cp0_addr));
      check({tag, "_epc"}, epc_out, m_epc);
    end
    r = m_req();
    i = m_int();
    @(posedge clk);
    if (reset) begin
      m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0; m_valid = 1'b1;
    end else begin
      if (r) begin
        m_sr    = m_sr | 32'h2;
        m_epc   = bd_in ? vpc - 32'd4 : vpc;
        m_cause = (bd_in ? 32'h8000_0000 : 32'h0) | (i ? 32'h0 : {27'd0, exc_code_in} << 2);
      end else begin
        if (en && cp0_addr == 5'd12) m_sr = cp0_in & 32'h0000_FC03;
        if (en && cp0_addr == 5'd14) m_epc = cp0_in;
        if (exl_clr) m_sr = m_sr & ~32'h2;
      end
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
    end
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    cp0_addr = a;
    #1;
    check(tag, cp0_out, exp);
  endtask

  task automatic idle();
    reset = 1'b0; en = 1'b0; exl_clr = 1'b0; bd_in = 1'b0;
    exc_code_in = 5'd0; hw_int = 6'd0; cp0_in = 32'h0; vpc = 32'h0; cp0_addr = 5'd0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick("rst");
    reset = 1'b0;
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd15, 32'h2022_0202, "rst_prid");
    rd(5'd3, 32'h0, "rst_other");
    check("rst_epc_out", epc_out, 32'h0);
    check("rst_req", {31'd0, req}, 32'h0);

    // Overflow, then a masked second exception
    exc_code_in = 5'd12; vpc = 32'h0000_3010;
    tick("ov");
    exc_code_in = 5'd4;
    rd(5'd13, 32'h0000_0030, "ov_cause");
    rd(5'd14, 32'h0000_3010, "ov_epc");
    rd(5'd12, 32'h0000_0002, "ov_sr");
    check("ov_masked_req", {31'd0, req}, 32'h0);
    tick("ov_masked");

    exc_code_in = 5'd0; exl_clr = 1'b1;
    tick("eret1");
    exl_clr = 1'b0;

    // Delay-slot AdES
    exc_code_in = 5'd5; bd_in = 1'b1; vpc = 32'h0000_3008;
    tick("ades");
    idle();
    rd(5'd14, 32'h0000_3004, "ades_epc");
    rd(5'd13, 32'h8000_0014, "ades_cause");

    // Cause and PRId writes are ignored; SR write clears EXL and arms IE/IM0
    en = 1'b1; cp0_addr = 5'd13; cp0_in = 32'hFFFF_FFFF;
    tick("wr_cause");
    cp0_addr = 5'd15;
    tick("wr_prid");
    cp0_addr = 5'd12; cp0_in = 32'h0000_0401;
    tick("wr_sr");
    en = 1'b0;
    rd(5'd13, 32'h8000_0014, "cause_ro");

    // Interrupt beats exception
    hw_int = 6'b000001; exc_code_in = 5'd12; vpc = 32'h0000_4000;
    tick("int");
    exc_code_in = 5'd0;
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd14, 32'h0000_4000, "int_epc");

    // eret with concurrent SR write
    hw_int = 6'd0; exl_clr = 1'b1; en = 1'b1; cp0_addr = 5'd12; cp0_in = 32'h0000_FC03;
    tick("eret_sr");
    exl_clr = 1'b0; en = 1'b0;
    rd(5'd12, 32'h0000_FC01, "eret_sr_val");

    // mtc0 EPC concurrent with an exception is dropped
    en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'hDEAD_BEEF; exc_code_in = 5'd8; vpc = 32'h0000_0100;
    tick("epc_drop");
    idle();
    rd(5'd14, 32'h0000_0100, "epc_drop_val");

    // Wrap-around EPC for a delay slot at address 0
    exl_clr = 1'b1;
    tick("eret2");
    exl_clr = 1'b0; exc_code_in = 5'd10; bd_in = 1'b1; vpc = 32'h0;
    tick("wrap");
    idle();
    rd(5'd14, 32'hFFFF_FFFC, "wrap_epc");

    // Reset in the handler with requesting inputs
    reset = 1'b1; exc_code_in = 5'd12; hw_int = 6'h3F;
    tick("mid_rst");
    idle();
    rd(5'd12, 32'h0, "mid_rst_sr");
    rd(5'd13, 32'h0, "mid_rst_cause");
    rd(5'd14, 32'h0, "mid_rst_epc");
    check("mid_rst_req", {31'd0, req}, 32'h0);

    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      en          = ($urandom_range(0, 2) == 0);
      cp0_addr    = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      cp0_in      = $urandom;
      vpc         = $urandom;
      bd_in       = 1'($urandom);
      exc_code_in = codes[$urandom_range(0, 7)];
      hw_int      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      exl_clr     = ($urandom_range(0, 4) == 0);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
